imem_fetch_unit: RTL and testbench
==================================

# imem_fetch_unit

Parametrised instruction memory with a handshaked fetch port and a program-load port, replacing the fixed 32-bit, 65536-word, combinational-read instruction memory. It sits between the PC/fetch stage and decode, supplies one instruction per cycle with a one-cycle registered read, and is filled by a loader (testbench or boot ROM) before execution starts. A three-state controller keeps loading and fetching mutually exclusive.

## Interface
Parameters:
- DATA_W, 32, instruction width in bits
- ADDR_W, 32, byte-address width of req_addr/load_addr
- DEPTH, 65536, number of instruction words; any positive integer, not necessarily a power of two
- NOP_INSTR, 0, instruction returned on an error response

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-low reset; sampled on the rising edge of clk
- load_valid  in  1  loader write request
- load_ready  out  1  write accepted this cycle when load_valid and load_ready are both high
- load_addr  in  ADDR_W  byte address of the word to write
- load_data  in  DATA_W  word to write
- load_done  in  1  single-cycle pulse: program complete
- load_cnt  out  clog2(DEPTH)+1  number of in-range words written since the last entry to ST_LOAD; saturates at DEPTH
- req_valid  in  1  fetch request
- req_ready  out  1  fetch request accepted when req_valid and req_ready are both high
- req_addr  in  ADDR_W  byte address (PC)
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts the response
- rsp_instr  out  DATA_W  fetched instruction
- rsp_err  out  1  response is an error (out of range, or misaligned when the trap is enabled)
- busy  out  1  state is not ST_RUN

## Operation
- Word index: idx = addr >> 2. An address is out of range when idx >= DEPTH.
- States:
  - ST_LOAD is the reset state. ST_LOAD goes to ST_RUN on load_done.
  - ST_RUN goes to ST_DRAIN on load_valid.
  - ST_DRAIN goes to ST_LOAD once rsp_valid is 0, or in the same cycle the last response handshakes.
- ST_LOAD:
  - load_ready = 1 and req_ready = 0.
  - An accepted in-range write updates mem[idx] and increments load_cnt.
  - Out-of-range writes are dropped and do not count.
- Entry to ST_LOAD from ST_DRAIN clears load_cnt. Memory contents are kept, so a partial reload is allowed.
- load_valid and load_done in the same cycle: the write is performed and counted, then the state moves to ST_RUN.
- ST_RUN:
  - load_ready = 0.
  - req_ready = !rsp_valid || rsp_ready.
  - An accepted request reads the array. On the next cycle rsp_valid = 1 and rsp_instr = mem[idx], with rsp_err = 0.
  - On an error the response is rsp_instr = NOP_INSTR and rsp_err = 1.
- ST_DRAIN: load_ready = 0 and req_ready = 0. Any pending response is held until it handshakes.
- Response stability: while rsp_valid && !rsp_ready, rsp_instr and rsp_err hold constant.
- A fetch is never combinational; data always comes from the array read register.
- Reset values: load_ready = 1, req_ready = 0, rsp_valid = 0, rsp_err = 0, rsp_instr = NOP_INSTR, load_cnt = 0, busy = 1, state = ST_LOAD. Memory contents are not reset.

## Timing
- Fetch latency: request accepted at edge N, response valid after edge N+1.
- Throughput: one fetch per cycle while rsp_ready = 1 (back-to-back).
- Backpressure: with rsp_ready = 0 and rsp_valid = 1, req_ready = 0 combinationally in the same cycle. No request is lost or duplicated.
- Load write: the written word is visible to a fetch accepted at least one cycle after ST_RUN is entered.
- Reset mid-operation (rst low at edge N): after edge N rsp_valid = 0, and any in-flight response is discarded. A load write presented in that cycle is not performed.
- load_done outside ST_LOAD is ignored. load_valid in ST_DRAIN is not accepted and is not lost; the loader keeps it asserted.

## Configuration
- IMEM_MISALIGN_TRAP_EN
  - Defined: a request with req_addr[1:0] != 0 produces rsp_err = 1 and rsp_instr = NOP_INSTR. A load write with load_addr[1:0] != 0 is dropped and not counted.
  - Undefined: addr[1:0] is ignored for both ports.

## Structure
- imem_pkg holds:
  - the state enum (ST_LOAD, ST_RUN, ST_DRAIN)
  - the byte-to-word shift constant (2)
  - a helper function computing the index width from DEPTH
- Sub-module imem_array: single-port synchronous RAM (DEPTH x DATA_W) with a registered read and write enable.
  - Single-port is sufficient because writes occur only in ST_LOAD and reads only in ST_RUN.
- Top level holds the controller FSM, the range/alignment checks, the response register and load_cnt.

## Test plan
- Load words 0x00000013, 0xDEADBEEF, 0x12345678 at byte addresses 0x0, 0x4, 0x8, then pulse load_done -> load_cnt = 3, busy = 0. Fetches to 0x4 and 0x8 return 0xDEADBEEF and 0x12345678 one cycle after acceptance, with rsp_err = 0.
- Back-to-back fetches 0x0, 0x4, 0x8 with rsp_ready held at 1 -> three consecutive rsp_valid cycles with the correct words.
- Hold rsp_ready = 0 for 3 cycles during a fetch of 0x4 -> req_ready = 0 and rsp_instr is stable at 0xDEADBEEF. Releasing rsp_ready completes exactly one handshake.
- Fetch byte address 4*DEPTH -> rsp_err = 1 and rsp_instr = NOP_INSTR. A load write to the same address leaves load_cnt unchanged.
- With IMEM_MISALIGN_TRAP_EN defined, fetch 0x6 -> rsp_err = 1. With it undefined, fetch 0x6 returns the word at 0x4.
- While a response is pending in ST_RUN, assert load_valid -> state goes to ST_DRAIN, then to ST_LOAD after the response handshakes, with load_cnt cleared to 0. Pulling rst low in ST_RUN drops rsp_valid at the next edge and sets busy = 1.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction memory fetch unit.
package imem_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int BYTE_SHIFT = 2;

  // A one-word memory still needs a one-bit address.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/imem_array.sv
// Single-port synchronous RAM, registered read; the read register holds between reads.
module imem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 65536,
  parameter int IDX_W  = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/imem_fetch_unit.sv
// Instruction memory with handshaked fetch and load ports and a load/run/drain controller.
// Optional macro IMEM_MISALIGN_TRAP_EN: misaligned fetches error, misaligned load writes are dropped.
module imem_fetch_unit
  import imem_pkg::*;
#(
  parameter int                 DATA_W    = 32,
  parameter int                 ADDR_W    = 32,
  parameter int                 DEPTH     = 65536,
  parameter logic [DATA_W-1:0]  NOP_INSTR = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [ADDR_W-1:0]       load_addr,
  input  logic [DATA_W-1:0]       load_data,
  input  logic                    load_done,
  output logic [$clog2(DEPTH):0]  load_cnt,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_W-1:0]       req_addr,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_W-1:0]       rsp_instr,
  output logic                    rsp_err,
  output logic                    busy
);

  localparam int                IDX_W   = idx_width(DEPTH);
  localparam int                CNT_W   = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEPTH);

  state_e            state_q, state_d;
  logic              rsp_valid_q, rsp_err_q, rsp_nop_q;
  logic [CNT_W-1:0]  load_cnt_q;
  logic [ADDR_W-1:0] req_word, load_word;
  logic              req_mis, load_mis;
  logic              req_ok, load_ok;
  logic              req_fire, load_fire;
  logic              mem_we, mem_re;
  logic [IDX_W-1:0]  mem_addr;
  logic [DATA_W-1:0] mem_rdata;

  assign req_word  = req_addr >> BYTE_SHIFT;
  assign load_word = load_addr >> BYTE_SHIFT;

`ifdef IMEM_MISALIGN_TRAP_EN
  assign req_mis  = |req_addr[BYTE_SHIFT-1:0];
  assign load_mis = |load_addr[BYTE_SHIFT-1:0];
`else
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^{req_addr[BYTE_SHIFT-1:0], load_addr[BYTE_SHIFT-1:0]};
  assign req_mis  = 1'b0;
  assign load_mis = 1'b0;
`endif

  assign req_ok    = (req_word < DEPTH_A) && !req_mis;
  assign load_ok   = (load_word < DEPTH_A) && !load_mis;
  assign req_fire  = req_valid && req_ready;
  assign load_fire = load_valid && load_ready;

  always_comb begin
    state_d    = state_q;
    load_ready = 1'b0;
    req_ready  = 1'b0;
    case (state_q)
      ST_LOAD: begin
        load_ready = 1'b1;
        if (load_done) state_d = ST_RUN;
      end
      ST_RUN: begin
        req_ready = !rsp_valid_q || rsp_ready;
        if (load_valid) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!rsp_valid_q || rsp_ready) state_d = ST_LOAD;
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_LOAD;
    else      state_q <= state_d;
  end

  // Only one port is ever active per state, so the address mux follows the state.
  assign mem_we   = rst && load_fire && load_ok;
  assign mem_re   = rst && req_fire && req_ok;
  assign mem_addr = (state_q == ST_LOAD) ? load_word[IDX_W-1:0] : req_word[IDX_W-1:0];

  imem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (mem_addr),
    .wdata (load_data),
    .rdata (mem_rdata)
  );

  // rsp_nop_q masks the unreset RAM output after reset and on error responses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_nop_q   <= 1'b1;
    end else if (req_fire) begin
      rsp_valid_q <= 1'b1;
      rsp_err_q   <= !req_ok;
      rsp_nop_q   <= !req_ok;
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      load_cnt_q <= '0;
    end else if (state_q == ST_DRAIN && state_d == ST_LOAD) begin
      load_cnt_q <= '0;
    end else if (load_fire && load_ok && load_cnt_q != CNT_MAX) begin
      load_cnt_q <= load_cnt_q + 1'b1;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_instr = rsp_nop_q ? NOP_INSTR : mem_rdata;
  assign load_cnt  = load_cnt_q;
  assign busy      = (state_q != ST_RUN);

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Scoreboard bench for imem_fetch_unit: responses are predicted from a model memory at request acceptance.
module tb_imem_fetch_unit;

  localparam int          DATA_W = 32;
  localparam int          ADDR_W = 32;
  localparam int          DEPTH  = 12;
  localparam logic [31:0] NOP    = 32'hA5A5_0001;

  logic        clk, rst;
  logic        load_valid, load_ready, load_done;
  logic [31:0] load_addr, load_data;
  logic [4:0]  load_cnt;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_instr;
  logic        busy;

  imem_fetch_unit #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .DEPTH     (DEPTH),
    .NOP_INSTR (NOP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .load_done  (load_done),
    .load_cnt   (load_cnt),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_instr  (rsp_instr),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } rsp_t;

  int          pass_cnt  = 0;
  int          total_cnt = 0;
  int          hs_cnt    = 0;
  int          exp_cnt   = 0;
  rsp_t        sb_q[$];
  logic [31:0] model_mem [DEPTH];

  function automatic logic addr_ok(input logic [31:0] a);
    logic ok;
    ok = (a >> 2) < DEPTH;
`ifdef IMEM_MISALIGN_TRAP_EN
    if (a[1:0] != 2'b00) ok = 1'b0;
`endif
    return ok;
  endfunction

  function automatic rsp_t expect_rsp(input logic [31:0] a);
    rsp_t r;
    if (addr_ok(a)) r = '{instr: model_mem[a >> 2], err: 1'b0};
    else            r = '{instr: NOP, err: 1'b1};
    return r;
  endfunction

  // Scoreboard: push on request acceptance, pop on response handshake, flush on reset.
  logic        prev_stall = 1'b0;
  logic [31:0] prev_instr;
  logic        prev_err;
  always @(negedge clk) begin
    if (!rst) begin
      sb_q.delete();
    end else begin
      if (prev_stall && rsp_valid) begin
        total_cnt++;
        if ({rsp_instr, rsp_err} !== {prev_instr, prev_err})
          $display("FAIL rsp_stable: got %h/%b required %h/%b", rsp_instr, rsp_err, prev_instr, prev_err);
        else pass_cnt++;
      end
      if (rsp_valid && rsp_ready) begin
        rsp_t e;
        hs_cnt++;
        total_cnt++;
        if (sb_q.size() == 0) begin
          $display("FAIL sb_unexpected: got %h/%b required no response", rsp_instr, rsp_err);
        end else begin
          e = sb_q.pop_front();
          if ({rsp_instr, rsp_err} !== e)
            $display("FAIL sb_rsp: got %h/%b required %h/%b", rsp_instr, rsp_err, e.instr, e.err);
          else pass_cnt++;
          $display("rsp instr=%h err=%b", rsp_instr, rsp_err);
        end
      end
      if (req_valid && req_ready) sb_q.push_back(expect_rsp(req_addr));
    end
    prev_stall = rst && rsp_valid && !rsp_ready;
    prev_instr = rsp_instr;
    prev_err   = rsp_err;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [31:0] a, input logic [31:0] d, input logic done);
    bit ok = 0;
    load_valid = 1'b1; load_addr = a; load_data = d; load_done = done;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (load_ready) begin ok = 1; break; end
    end
    total_cnt++;
    if (!ok) $display("FAIL load_timeout: got load_ready=0 required 1 addr=%h", a);
    else pass_cnt++;
    step();
    load_valid = 1'b0; load_done = 1'b0;
    if (ok && addr_ok(a)) begin
      model_mem[a >> 2] = d;
      exp_cnt++;
    end
    $display("load addr=%h data=%h done=%b", a, d, done);
  endtask

  task automatic fetch(input logic [31:0] a);
    bit ok = 0;
    req_valid = 1'b1; req_addr = a;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1; break; end
      step();
    end
    total_cnt++;
    if (!ok) $display("FAIL fetch_timeout: got req_ready=0 required 1 addr=%h", a);
    else pass_cnt++;
    step();
    req_valid = 1'b0;
    $display("fetch addr=%h", a);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step(); step();
    @(negedge clk);
    total_cnt += 7;
    if (load_ready !== 1'b1) $display("FAIL rst_load_ready: got %b required 1", load_ready); else pass_cnt++;
    if (req_ready !== 1'b0)  $display("FAIL rst_req_ready: got %b required 0", req_ready); else pass_cnt++;
    if (rsp_valid !== 1'b0)  $display("FAIL rst_rsp_valid: got %b required 0", rsp_valid); else pass_cnt++;
    if (rsp_err !== 1'b0)    $display("FAIL rst_rsp_err: got %b required 0", rsp_err); else pass_cnt++;
    if (rsp_instr !== NOP)   $display("FAIL rst_rsp_instr: got %h required %h", rsp_instr, NOP); else pass_cnt++;
    if (load_cnt !== 5'd0)   $display("FAIL rst_load_cnt: got %0d required 0", load_cnt); else pass_cnt++;
    if (busy !== 1'b1)       $display("FAIL rst_busy: got %b required 1", busy); else pass_cnt++;
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_load();
    load_word(32'h0, 32'h0000_0013, 1'b0);
    load_word(32'h4, 32'hDEAD_BEEF, 1'b0);
    load_word(32'h8, 32'h1234_5678, 1'b0);
    @(negedge clk);
    total_cnt += 2;
    if (load_cnt !== 5'd3) $display("FAIL load_cnt3: got %0d required 3", load_cnt); else pass_cnt++;
    if (busy !== 1'b1)     $display("FAIL load_busy: got %b required 1", busy); else pass_cnt++;
    step();
    load_done = 1'b1;
    step();
    load_done = 1'b0;
    @(negedge clk);
    total_cnt += 3;
    if (busy !== 1'b0)       $display("FAIL run_busy: got %b required 0", busy); else pass_cnt++;
    if (load_ready !== 1'b0) $display("FAIL run_load_ready: got %b required 0", load_ready); else pass_cnt++;
    if (load_cnt !== 5'd3)   $display("FAIL run_load_cnt: got %0d required 3", load_cnt); else pass_cnt++;
    step();
  endtask

  task automatic test_fetch();
    rsp_ready = 1'b1;
    fetch(32'h4);
    @(negedge clk);
    total_cnt += 2;
    if (rsp_valid !== 1'b1) $display("FAIL lat_valid: got %b required 1", rsp_valid); else pass_cnt++;
    if ({rsp_instr, rsp_err} !== {32'hDEAD_BEEF, 1'b0})
      $display("FAIL lat_data4: got %h/%b required deadbeef/0", rsp_instr, rsp_err);
    else pass_cnt++;
    step();
    fetch(32'h8);
    @(negedge clk);
    total_cnt++;
    if ({rsp_instr, rsp_err} !== {32'h1234_5678, 1'b0})
      $display("FAIL lat_data8: got %h/%b required 12345678/0", rsp_instr, rsp_err);
    else pass_cnt++;
    step();
  endtask

  task automatic test_back_to_back();
    int nvalid = 0;
    int hs0 = hs_cnt;
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_addr = 32'(i * 4);
      @(negedge clk);
      total_cnt++;
      if (req_ready !== 1'b1) $display("FAIL b2b_ready%0d: got %b required 1", i, req_ready); else pass_cnt++;
      if (rsp_valid) nvalid++;
      step();
    end
    req_valid = 1'b0;
    @(negedge clk);
    if (rsp_valid) nvalid++;
    step();
    @(negedge clk);
    total_cnt += 3;
    if (nvalid != 3)        $display("FAIL b2b_valid_cycles: got %0d required 3", nvalid); else pass_cnt++;
    if (hs_cnt - hs0 != 3)  $display("FAIL b2b_handshakes: got %0d required 3", hs_cnt - hs0); else pass_cnt++;
    if (rsp_valid !== 1'b0) $display("FAIL b2b_idle: got %b required 0", rsp_valid); else pass_cnt++;
    step();
  endtask

  task automatic test_backpressure();
    int hs0;
    rsp_ready = 1'b0;
    fetch(32'h4);
    req_valid = 1'b1; req_addr = 32'h8;
    hs0 = hs_cnt;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total_cnt += 3;
      if (req_ready !== 1'b0) $display("FAIL bp_req_ready%0d: got %b required 0", i, req_ready); else pass_cnt++;
      if (rsp_valid !== 1'b1) $display("FAIL bp_valid%0d: got %b required 1", i, rsp_valid); else pass_cnt++;
      if (rsp_instr !== 32'hDEAD_BEEF) $display("FAIL bp_instr%0d: got %h required deadbeef", i, rsp_instr); else pass_cnt++;
      step();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (req_ready !== 1'b1) $display("FAIL bp_release_ready: got %b required 1", req_ready); else pass_cnt++;
    step();
    rsp_ready = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    total_cnt += 2;
    if (hs_cnt - hs0 != 1) $display("FAIL bp_one_handshake: got %0d required 1", hs_cnt - hs0); else pass_cnt++;
    if ({rsp_valid, rsp_instr} !== {1'b1, 32'h1234_5678})
      $display("FAIL bp_next: got %b/%h required 1/12345678", rsp_valid, rsp_instr);
    else pass_cnt++;
    step();
    rsp_ready = 1'b1;
    step();
  endtask

  task automatic test_out_of_range();
    rsp_ready = 1'b1;
    fetch(32'(4 * DEPTH));
    @(negedge clk);
    total_cnt++;
    if ({rsp_valid, rsp_err, rsp_instr} !== {1'b1, 1'b1, NOP})
      $display("FAIL oor_fetch: got %b/%b/%h required 1/1/%h", rsp_valid, rsp_err, rsp_instr, NOP);
    else pass_cnt++;
    step();
    fetch(32'h6);
    @(negedge clk);
    total_cnt++;
`ifdef IMEM_MISALIGN_TRAP_EN
    if ({rsp_err, rsp_instr} !== {1'b1, NOP})
      $display("FAIL misalign_fetch: got %b/%h required 1/%h", rsp_err, rsp_instr, NOP);
    else pass_cnt++;
`else
    if ({rsp_err, rsp_instr} !== {1'b0, 32'hDEAD_BEEF})
      $display("FAIL misalign_fetch: got %b/%h required 0/deadbeef", rsp_err, rsp_instr);
    else pass_cnt++;
`endif
    step();
  endtask

  task automatic test_drain_reload();
    rsp_ready = 1'b0;
    fetch(32'h0);
    load_valid = 1'b1; load_addr = 32'h0; load_data = 32'h1111_1111;
    @(negedge clk);
    total_cnt++;
    if (load_ready !== 1'b0) $display("FAIL run_no_load: got %b required 0", load_ready); else pass_cnt++;
    for (int i = 0; i < 2; i++) begin
      step();
      @(negedge clk);
      total_cnt += 3;
      if (busy !== 1'b1)       $display("FAIL drain_busy%0d: got %b required 1", i, busy); else pass_cnt++;
      if (load_ready !== 1'b0) $display("FAIL drain_load_ready%0d: got %b required 0", i, load_ready); else pass_cnt++;
      if ({req_ready, rsp_valid} !== 2'b01)
        $display("FAIL drain_hold%0d: got req_ready/rsp_valid %b required 01", i, {req_ready, rsp_valid});
      else pass_cnt++;
    end
    step();
    rsp_ready = 1'b1;
    step();
    @(negedge clk);
    total_cnt += 2;
    if ({load_ready, busy, rsp_valid} !== 3'b110)
      $display("FAIL reload_state: got load_ready/busy/rsp_valid %b required 110", {load_ready, busy, rsp_valid});
    else pass_cnt++;
    if (load_cnt !== 5'd0) $display("FAIL reload_cnt_clear: got %0d required 0", load_cnt); else pass_cnt++;
    step();
    load_valid = 1'b0;
    model_mem[0] = 32'h1111_1111;
    exp_cnt = 1;
    @(negedge clk);
    total_cnt++;
    if (load_cnt !== 5'd1) $display("FAIL reload_cnt1: got %0d required 1", load_cnt); else pass_cnt++;
    step();
    load_word(32'(4 * DEPTH), 32'h0BAD_0BAD, 1'b0);
    @(negedge clk);
    total_cnt++;
    if (load_cnt !== 5'd1) $display("FAIL oor_load_cnt: got %0d required 1", load_cnt); else pass_cnt++;
    step();
    load_word(32'h5, 32'h5555_5555, 1'b0);
    @(negedge clk);
    total_cnt++;
    if (load_cnt !== 5'(exp_cnt)) $display("FAIL misalign_load_cnt: got %0d required %0d", load_cnt, exp_cnt); else pass_cnt++;
    step();
    load_word(32'h8, 32'h8765_4321, 1'b1);
    @(negedge clk);
    total_cnt += 2;
    if (load_cnt !== 5'(exp_cnt)) $display("FAIL done_write_cnt: got %0d required %0d", load_cnt, exp_cnt); else pass_cnt++;
    if (busy !== 1'b0) $display("FAIL done_write_run: got %b required 0", busy); else pass_cnt++;
    step();
    fetch(32'h0);
    fetch(32'h4);
    fetch(32'h8);
    step();
    step();
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b0;
    fetch(32'h4);
    rst = 1'b0;
    step();
    @(negedge clk);
    total_cnt += 3;
    if (rsp_valid !== 1'b0) $display("FAIL midrst_valid: got %b required 0", rsp_valid); else pass_cnt++;
    if (busy !== 1'b1)      $display("FAIL midrst_busy: got %b required 1", busy); else pass_cnt++;
    if ({load_ready, load_cnt} !== {1'b1, 5'd0})
      $display("FAIL midrst_load: got %b/%0d required 1/0", load_ready, load_cnt);
    else pass_cnt++;
    step();
    rst = 1'b1;
    rsp_ready = 1'b1;
    step();
  endtask

  initial begin
    rst = 1'b0; load_valid = 1'b0; load_addr = '0; load_data = '0; load_done = 1'b0;
    req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
    test_reset();
    test_load();
    test_fetch();
    test_back_to_back();
    test_backpressure();
    test_out_of_range();
    test_drain_reload();
    test_reset_mid();
    @(negedge clk);
    total_cnt++;
    if (sb_q.size() != 0) $display("FAIL sb_leftover: got %0d required 0", sb_q.size()); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
